// File: rtl/VX_gpu_pkg.sv
// Shared state encoding and bank-select helper for the lmem bank scheduler.
// Build option: LMEM_BCAST_EN (used by lmem_bank_sched) enables same-address read broadcast.
package VX_gpu_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RSP   = 2'd3
    } lmem_sched_state_t;

    // Bank index of a word address; num_banks is a power of two.
    function automatic int unsigned lmem_bank_sel(input logic [31:0] addr, input int unsigned num_banks);
        return addr & (num_banks - 1);
    endfunction

endpackage

// File: rtl/lmem_bank_sched_if.sv
// LSU-side request/response bus of the lmem bank scheduler.
// master = LSU (request issuer), slave = scheduler.
interface lmem_bank_sched_if #(
    parameter int NUM_LANES  = 4,
    parameter int WORD_SIZE  = 4,
    parameter int ADDR_WIDTH = 12,
    parameter int TAG_WIDTH  = 8
);
    logic                                  req_valid;
    logic                                  req_ready;
    logic                                  req_rw;
    logic [NUM_LANES-1:0]                  req_mask;
    logic [NUM_LANES-1:0][WORD_SIZE-1:0]   req_byteen;
    logic [NUM_LANES-1:0][ADDR_WIDTH-1:0]  req_addr;
    logic [NUM_LANES-1:0][WORD_SIZE*8-1:0] req_data;
    logic [TAG_WIDTH-1:0]                  req_tag;

    logic                                  rsp_valid;
    logic                                  rsp_ready;
    logic [NUM_LANES-1:0]                  rsp_mask;
    logic [NUM_LANES-1:0][WORD_SIZE*8-1:0] rsp_data;
    logic [TAG_WIDTH-1:0]                  rsp_tag;

    modport master (
        output req_valid, req_rw, req_mask, req_byteen, req_addr, req_data, req_tag, rsp_ready,
        input  req_ready, rsp_valid, rsp_mask, rsp_data, rsp_tag
    );

    modport slave (
        input  req_valid, req_rw, req_mask, req_byteen, req_addr, req_data, req_tag, rsp_ready,
        output req_ready, rsp_valid, rsp_mask, rsp_data, rsp_tag
    );
endinterface

// File: rtl/lmem_bank_grant.sv
// Per-bank arbiter: picks the lowest-index requesting lane as a one-hot grant.
module lmem_bank_grant #(
    parameter int N = 4
) (
    input  logic [N-1:0] i_match,
    output logic [N-1:0] o_grant,
    output logic         o_valid
);
    // NOTE: every output of an always_comb gets a default first so no path can infer a latch.
    always_comb begin
        o_grant = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (i_match[i]) begin
                o_grant    = '0;
                o_grant[i] = 1'b1;
            end
        end
    end

    assign o_valid = |i_match;
endmodule

// File: rtl/lmem_bank_sched.sv
// Bank-conflict scheduler: spreads one multi-lane lmem request over NUM_BANKS single-port banks.
// Build option: LMEM_BCAST_EN makes same-address read lanes share one bank access.
module lmem_bank_sched
    import VX_gpu_pkg::*;
#(
    parameter  int NUM_LANES     = 4,
    parameter  int NUM_BANKS     = 4,
    parameter  int WORD_SIZE     = 4,
    parameter  int ADDR_WIDTH    = 12,
    parameter  int TAG_WIDTH     = 8,
    localparam int BANK_SEL_BITS = $clog2(NUM_BANKS),
    localparam int ROW_WIDTH     = ADDR_WIDTH - BANK_SEL_BITS,
    localparam int WORD_BITS     = WORD_SIZE * 8
) (
    input  logic                                 clk,
    input  logic                                 reset,
    lmem_bank_sched_if.slave                     bus,
    output logic [NUM_BANKS-1:0]                 bank_valid,
    output logic [NUM_BANKS-1:0]                 bank_rw,
    output logic [NUM_BANKS-1:0][ROW_WIDTH-1:0]  bank_addr,
    output logic [NUM_BANKS-1:0][WORD_SIZE-1:0]  bank_byteen,
    output logic [NUM_BANKS-1:0][WORD_BITS-1:0]  bank_wdata,
    input  logic [NUM_BANKS-1:0][WORD_BITS-1:0]  bank_rdata,
    output logic [31:0]                          perf_conflicts
);
    lmem_sched_state_t r_state, w_next_state;

    logic                                  r_rw;
    logic [NUM_LANES-1:0]                  r_mask, r_pending, r_capture;
    logic [NUM_LANES-1:0][WORD_SIZE-1:0]   r_byteen;
    logic [NUM_LANES-1:0][ADDR_WIDTH-1:0]  r_addr;
    logic [NUM_LANES-1:0][WORD_BITS-1:0]   r_data, r_rsp_data;
    logic [TAG_WIDTH-1:0]                  r_tag;
    logic                                  r_first_issue;
    logic [31:0]                           r_perf;

    logic [NUM_BANKS-1:0][NUM_LANES-1:0]   w_match, w_grant;
    logic [NUM_BANKS-1:0]                  w_bank_hit;
    logic [NUM_LANES-1:0]                  w_lane_grant, w_next_pending;
    logic                                  w_accept;
`ifdef LMEM_BCAST_EN
    logic [NUM_BANKS-1:0][ADDR_WIDTH-1:0]  w_bank_full_addr;
`endif

    assign w_accept = bus.req_valid && bus.req_ready;

    always_comb begin
        w_match = '0;
        for (int b = 0; b < NUM_BANKS; b++) begin
            for (int l = 0; l < NUM_LANES; l++) begin
                w_match[b][l] = (r_state == ISSUE) && r_pending[l] &&
                                (lmem_bank_sel(32'(r_addr[l]), NUM_BANKS) == b);
            end
        end
    end

    for (genvar gb = 0; gb < NUM_BANKS; gb++) begin : g_bank
        lmem_bank_grant #(.N(NUM_LANES)) u_grant (
            .i_match (w_match[gb]),
            .o_grant (w_grant[gb]),
            .o_valid (w_bank_hit[gb])
        );
    end

    // Bank outputs follow the granted lane; broadcast lanes ride on the same read.
    always_comb begin
        bank_valid   = w_bank_hit;
        bank_rw      = '0;
        bank_addr    = '0;
        bank_byteen  = '0;
        bank_wdata   = '0;
        w_lane_grant = '0;
`ifdef LMEM_BCAST_EN
        w_bank_full_addr = '0;
`endif
        for (int b = 0; b < NUM_BANKS; b++) begin
            bank_rw[b] = w_bank_hit[b] & r_rw;
            for (int l = 0; l < NUM_LANES; l++) begin
                if (w_grant[b][l]) begin
                    bank_addr[b]   = r_addr[l][ADDR_WIDTH-1:BANK_SEL_BITS];
                    bank_byteen[b] = r_byteen[l];
                    bank_wdata[b]  = r_data[l];
`ifdef LMEM_BCAST_EN
                    w_bank_full_addr[b] = r_addr[l];
`endif
                end
            end
            w_lane_grant = w_lane_grant | w_grant[b];
`ifdef LMEM_BCAST_EN
            for (int l = 0; l < NUM_LANES; l++) begin
                if (w_bank_hit[b] && !r_rw && w_match[b][l] && (r_addr[l] == w_bank_full_addr[b]))
                    w_lane_grant[l] = 1'b1;
            end
`endif
        end
    end

    assign w_next_pending = r_pending & ~w_lane_grant;

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE:    if (bus.req_valid && (bus.req_mask != '0)) w_next_state = ISSUE;
            ISSUE:   if (w_next_pending == '0) w_next_state = r_rw ? IDLE : WAIT;
            WAIT:    w_next_state = RSP;
            RSP:     if (bus.rsp_ready) w_next_state = IDLE;
            default: w_next_state = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state       <= IDLE;
            r_pending     <= '0;
            r_capture     <= '0;
            r_first_issue <= 1'b0;
            r_perf        <= '0;
        end else begin
            r_state   <= w_next_state;
            r_capture <= ((r_state == ISSUE) && !r_rw) ? w_lane_grant : '0;
            if (r_state == ISSUE) begin
                r_pending     <= w_next_pending;
                r_first_issue <= 1'b0;
                if (!r_first_issue) r_perf <= r_perf + 32'd1;
            end
            if (w_accept) begin
                r_pending     <= bus.req_mask;
                r_first_issue <= 1'b1;
            end
        end
    end

    // NOTE: payload/data registers carry no reset; the FSM guarantees they are loaded before use.
    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_rw       <= bus.req_rw;
            r_mask     <= bus.req_mask;
            r_byteen   <= bus.req_byteen;
            r_addr     <= bus.req_addr;
            r_data     <= bus.req_data;
            r_tag      <= bus.req_tag;
            r_rsp_data <= '0;
        end else begin
            for (int l = 0; l < NUM_LANES; l++) begin
                for (int b = 0; b < NUM_BANKS; b++) begin
                    if (r_capture[l] && (lmem_bank_sel(32'(r_addr[l]), NUM_BANKS) == b))
                        r_rsp_data[l] <= bank_rdata[b];
                end
            end
        end
    end

    assign bus.req_ready  = (r_state == IDLE);
    assign bus.rsp_valid  = (r_state == RSP);
    assign bus.rsp_mask   = r_mask;
    assign bus.rsp_data   = r_rsp_data;
    assign bus.rsp_tag    = r_tag;
    assign perf_conflicts = r_perf;
endmodule

// File: tb/tb_lmem_bank_sched.sv
// Self-checking bench for lmem_bank_sched: directed corner cases plus randomized traffic vs a flat-memory model.
module tb_lmem_bank_sched;
    localparam int NL   = 4;
    localparam int NB   = 4;
    localparam int WS   = 4;
    localparam int AW   = 12;
    localparam int TW   = 8;
    localparam int RW   = AW - 2;
    localparam int ROWS = 1 << RW;
    localparam int NWORDS = 1 << AW;

    typedef logic [NL-1:0][AW-1:0] addr_vec_t;
    typedef logic [NL-1:0][31:0]   data_vec_t;
    typedef logic [NL-1:0][WS-1:0] be_vec_t;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    lmem_bank_sched_if #(.NUM_LANES(NL), .WORD_SIZE(WS), .ADDR_WIDTH(AW), .TAG_WIDTH(TW)) bus ();

    logic [NB-1:0]          bank_valid, bank_rw;
    logic [NB-1:0][RW-1:0]  bank_addr;
    logic [NB-1:0][WS-1:0]  bank_byteen;
    logic [NB-1:0][31:0]    bank_wdata, bank_rdata;
    logic [31:0]            perf_conflicts;

    lmem_bank_sched #(.NUM_LANES(NL), .NUM_BANKS(NB), .WORD_SIZE(WS), .ADDR_WIDTH(AW), .TAG_WIDTH(TW)) dut (
        .clk            (clk),
        .reset          (reset),
        .bus            (bus),
        .bank_valid     (bank_valid),
        .bank_rw        (bank_rw),
        .bank_addr      (bank_addr),
        .bank_byteen    (bank_byteen),
        .bank_wdata     (bank_wdata),
        .bank_rdata     (bank_rdata),
        .perf_conflicts (perf_conflicts)
    );

    int n_vec  = 0;
    int n_miss = 0;
    int model_perf = 0;
    logic [31:0] ref_mem [NWORDS];
    logic [31:0] sram [NB][ROWS];

    // Bank SRAMs indexed by (bank,row); reloaded from the flat model while reset is held.
    always @(posedge clk) begin
        if (reset) begin
            for (int r = 0; r < ROWS; r++)
                for (int b = 0; b < NB; b++)
                    sram[b][r] <= ref_mem[r * NB + b];
        end else begin
            for (int b = 0; b < NB; b++) begin
                if (bank_valid[b]) begin
                    if (bank_rw[b]) begin
                        for (int j = 0; j < WS; j++)
                            if (bank_byteen[b][j]) sram[b][bank_addr[b]][8*j +: 8] <= bank_wdata[b][8*j +: 8];
                    end else begin
                        bank_rdata[b] <= sram[b][bank_addr[b]];
                    end
                end
            end
        end
    end

    task automatic run_txn(input string name, input logic rw, input logic [NL-1:0] mask,
                           input addr_vec_t addr, input data_vec_t data, input be_vec_t be, input int hold);
        logic [RW-1:0] exp_q  [NB][$];
        logic [RW-1:0] got_q  [NB][$];
        logic [AW-1:0] seen_q [NB][$];
        data_vec_t     exp_data;
        logic [TW-1:0] tag;
        int k, n, b, issue_cnt, exp_lat;
        bit dup, done, rw_ok, misc_ok, order_ok, hold_ok;

        k = 0;
        exp_data = '0;
        for (int l = 0; l < NL; l++) begin
            if (mask[l]) begin
                b   = int'(addr[l]) % NB;
                dup = 1'b0;
`ifdef LMEM_BCAST_EN
                if (!rw) foreach (seen_q[b][i]) if (seen_q[b][i] == addr[l]) dup = 1'b1;
`endif
                if (!dup) begin
                    seen_q[b].push_back(addr[l]);
                    exp_q[b].push_back(RW'(int'(addr[l]) / NB));
                end
                if (!rw) exp_data[l] = ref_mem[addr[l]];
            end
        end
        for (int i = 0; i < NB; i++) if (exp_q[i].size() > k) k = exp_q[i].size();

        tag = TW'($urandom);
        @(negedge clk);
        n_vec++;
        if (bus.req_ready !== 1'b1) begin
            n_miss++;
            $display("FAIL %s ready_before_req: got %b expected 1", name, bus.req_ready);
        end
        bus.req_valid  = 1'b1;
        bus.req_rw     = rw;
        bus.req_mask   = mask;
        bus.req_addr   = addr;
        bus.req_data   = data;
        bus.req_byteen = be;
        bus.req_tag    = tag;
        @(posedge clk);
        #1;
        bus.req_valid = 1'b0;
        bus.req_rw    = 1'($urandom);
        bus.req_mask  = NL'($urandom);
        bus.req_tag   = TW'($urandom);
        for (int l = 0; l < NL; l++) begin
            bus.req_addr[l]   = AW'($urandom);
            bus.req_data[l]   = $urandom;
            bus.req_byteen[l] = WS'($urandom);
        end

        if (mask == '0) begin
            misc_ok = 1'b1;
            repeat (3) begin
                @(negedge clk);
                if (bank_valid !== '0 || bus.req_ready !== 1'b1 || bus.rsp_valid !== 1'b0) misc_ok = 1'b0;
            end
            n_vec++;
            if (!misc_ok) begin
                n_miss++;
                $display("FAIL %s empty_mask_idle: got activity expected none", name);
            end
            return;
        end

        n = 0; issue_cnt = 0; done = 1'b0; rw_ok = 1'b1; misc_ok = 1'b1;
        while (!done && n < 64) begin
            @(negedge clk);
            if (bank_valid !== '0) begin
                issue_cnt++;
                for (int i = 0; i < NB; i++) begin
                    if (bank_valid[i]) begin
                        got_q[i].push_back(bank_addr[i]);
                        if (bank_rw[i] !== rw) rw_ok = 1'b0;
                    end
                end
            end
            if (rw && bus.rsp_valid) misc_ok = 1'b0;
            if (!rw && bus.req_ready) misc_ok = 1'b0;
            if (rw ? bus.req_ready : bus.rsp_valid) done = 1'b1;
            else n++;
        end

        exp_lat = rw ? k : k + 1;
        n_vec++;
        if (n !== exp_lat) begin
            n_miss++;
            $display("FAIL %s latency: got %0d cycles expected %0d", name, n, exp_lat);
        end
        n_vec++;
        if (issue_cnt !== k) begin
            n_miss++;
            $display("FAIL %s issue_cycles: got %0d expected %0d", name, issue_cnt, k);
        end
        order_ok = 1'b1;
        for (int i = 0; i < NB; i++) begin
            if (got_q[i].size() != exp_q[i].size()) order_ok = 1'b0;
            else foreach (exp_q[i][j]) if (got_q[i][j] !== exp_q[i][j]) order_ok = 1'b0;
        end
        n_vec++;
        if (!order_ok || !rw_ok || !misc_ok) begin
            n_miss++;
            $display("FAIL %s bank_access_sequence: got order_ok=%b rw_ok=%b handshake_ok=%b expected 1/1/1",
                     name, order_ok, rw_ok, misc_ok);
        end

        if (!rw) begin
            n_vec++;
            if (bus.rsp_data !== exp_data || bus.rsp_mask !== mask || bus.rsp_tag !== tag) begin
                n_miss++;
                $display("FAIL %s response: got data=%h mask=%b tag=%h expected data=%h mask=%b tag=%h",
                         name, bus.rsp_data, bus.rsp_mask, bus.rsp_tag, exp_data, mask, tag);
            end
            hold_ok = 1'b1;
            repeat (hold) begin
                @(negedge clk);
                if (bus.rsp_valid !== 1'b1 || bus.req_ready !== 1'b0 || bus.rsp_data !== exp_data ||
                    bus.rsp_mask !== mask || bus.rsp_tag !== tag) hold_ok = 1'b0;
            end
            if (hold > 0) begin
                n_vec++;
                if (!hold_ok) begin
                    n_miss++;
                    $display("FAIL %s rsp_hold_stable: got unstable response over %0d stalled cycles expected stable", name, hold);
                end
            end
            bus.rsp_ready = 1'b1;
            @(posedge clk);
            #1;
            bus.rsp_ready = 1'b0;
            @(negedge clk);
            n_vec++;
            if (bus.req_ready !== 1'b1 || bus.rsp_valid !== 1'b0) begin
                n_miss++;
                $display("FAIL %s post_handshake_idle: got ready=%b rsp_valid=%b expected 1/0",
                         name, bus.req_ready, bus.rsp_valid);
            end
        end else begin
            for (int l = 0; l < NL; l++)
                if (mask[l])
                    for (int j = 0; j < WS; j++)
                        if (be[l][j]) ref_mem[addr[l]][8*j +: 8] = data[l][8*j +: 8];
        end

        model_perf += k - 1;
        n_vec++;
        if (perf_conflicts !== 32'(model_perf)) begin
            n_miss++;
            $display("FAIL %s perf_conflicts: got %0d expected %0d", name, perf_conflicts, model_perf);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        n_vec++;
        if (bus.req_ready !== 1'b1 || bus.rsp_valid !== 1'b0 || bank_valid !== '0 || perf_conflicts !== 32'd0) begin
            n_miss++;
            $display("FAIL reset_state: got ready=%b rsp_valid=%b bank_valid=%b perf=%0d expected 1/0/0/0",
                     bus.req_ready, bus.rsp_valid, bank_valid, perf_conflicts);
        end
        reset = 1'b0;
        model_perf = 0;
    endtask

    task automatic test_no_conflict();
        addr_vec_t a;
        for (int l = 0; l < NL; l++) a[l] = AW'(l);
        run_txn("no_conflict", 1'b0, 4'b1111, a, '0, '1, 0);
    endtask

    task automatic test_all_bank0();
        addr_vec_t a;
        for (int l = 0; l < NL; l++) a[l] = AW'(4 * l);
        run_txn("all_bank0", 1'b0, 4'b1111, a, '0, '1, 0);
    endtask

    task automatic test_same_addr();
        addr_vec_t a;
        for (int l = 0; l < NL; l++) a[l] = AW'(5);
        run_txn("same_addr", 1'b0, 4'b1111, a, '0, '1, 0);
    endtask

    task automatic test_write_byteen();
        addr_vec_t a;
        data_vec_t d;
        be_vec_t   be;
        for (int l = 0; l < NL; l++) begin
            a[l]  = AW'($urandom);
            d[l]  = $urandom;
            be[l] = 4'b0011;
        end
        a[0] = AW'(2);
        a[2] = AW'(6);
        run_txn("write_byteen", 1'b1, 4'b0101, a, d, be, 0);
        a[1] = AW'(6);
        a[3] = AW'(7);
        run_txn("write_readback", 1'b0, 4'b1111, a, '0, '1, 0);
    endtask

    task automatic test_rsp_hold();
        addr_vec_t a;
        for (int l = 0; l < NL; l++) a[l] = AW'(8 + 3 * l);
        run_txn("rsp_hold", 1'b0, 4'b1011, a, '0, '1, 5);
    endtask

    task automatic test_mask_zero();
        addr_vec_t a;
        for (int l = 0; l < NL; l++) a[l] = AW'(l);
        run_txn("mask_zero", 1'b0, 4'b0000, a, '0, '1, 0);
        run_txn("after_mask_zero", 1'b0, 4'b0110, a, '0, '1, 0);
    endtask

    task automatic test_random();
        addr_vec_t a;
        data_vec_t d;
        be_vec_t   be;
        logic      rw;
        logic [NL-1:0] m;
        for (int t = 0; t < 60; t++) begin
            rw = ($urandom_range(0, 2) == 0);
            m  = ($urandom_range(0, 9) == 0) ? '0 : NL'($urandom);
            for (int l = 0; l < NL; l++) begin
                a[l]  = AW'($urandom_range(0, 23));
                d[l]  = $urandom;
                be[l] = WS'($urandom);
            end
            if ($urandom_range(0, 4) == 0) for (int l = 1; l < NL; l++) a[l] = a[0];
            run_txn("random", rw, m, a, d, be, $urandom_range(0, 2));
        end
    endtask

    task automatic test_reset_mid_issue();
        bit saw_rsp;
        @(negedge clk);
        bus.req_valid = 1'b1;
        bus.req_rw    = 1'b0;
        bus.req_mask  = 4'b1111;
        for (int l = 0; l < NL; l++) bus.req_addr[l] = AW'(4 * l + 1);
        @(posedge clk);
        #1;
        bus.req_valid = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        n_vec++;
        if (bus.req_ready !== 1'b1 || bank_valid !== '0 || perf_conflicts !== 32'd0 || bus.rsp_valid !== 1'b0) begin
            n_miss++;
            $display("FAIL reset_mid_issue: got ready=%b bank_valid=%b perf=%0d rsp_valid=%b expected 1/0/0/0",
                     bus.req_ready, bank_valid, perf_conflicts, bus.rsp_valid);
        end
        reset = 1'b0;
        model_perf = 0;
        saw_rsp = 1'b0;
        repeat (10) begin
            @(negedge clk);
            if (bus.rsp_valid !== 1'b0 || bank_valid !== '0) saw_rsp = 1'b1;
        end
        n_vec++;
        if (saw_rsp) begin
            n_miss++;
            $display("FAIL reset_drops_request: got activity after reset expected none");
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "simulation timeout");
    end

    initial begin
        for (int i = 0; i < NWORDS; i++) ref_mem[i] = $urandom;
        reset          = 1'b1;
        bus.req_valid  = 1'b0;
        bus.req_rw     = 1'b0;
        bus.req_mask   = '0;
        bus.req_addr   = '0;
        bus.req_data   = '0;
        bus.req_byteen = '0;
        bus.req_tag    = '0;
        bus.rsp_ready  = 1'b0;

        test_reset();
        test_no_conflict();
        test_all_bank0();
        test_same_addr();
        test_write_byteen();
        test_rsp_hold();
        test_mask_zero();
        test_random();
        test_reset_mid_issue();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end
endmodule
